// File: rtl/control_seq.sv
// control_seq: multi-cycle FETCH/EXEC/HALT sequencer for the accumulator CPU.
// It drives the instruction-memory fetch handshake, decodes the opcode into datapath strobes,
// and handles absolute jumps, zero-flag branches and CALL/RET through a bounded stack.
// Ports:
//   i_clk, i_rst (async, active low)
//   i_Data, i_imem_vld : instruction word and its valid flag, sampled in FETCH only
//   i_zero             : accumulator-is-zero flag, sampled in EXEC
//   o_imem_req, o_Addr : fetch request and PC
//   o_Data             : IR operand field
//   sel_A, sel_B, o_op : datapath selects, meaningful in EXEC only
//   w_acc, w_ram, r_ram : datapath strobes, meaningful in EXEC only
//   h_flg, o_err       : halted, and halted because of a fault
module control_seq #(
    parameter int BITS      = 16,
    parameter int OPBITS    = 5,
    parameter int DTBITS    = BITS - OPBITS,
    parameter int STK_DEPTH = 4,
    parameter int PC_RST    = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BITS-1:0]   i_Data,
    input  logic              i_imem_vld,
    input  logic              i_zero,
    output logic              o_imem_req,
    output logic [DTBITS-1:0] o_Addr,
    output logic [DTBITS-1:0] o_Data,
    output logic [1:0]        sel_A,
    output logic              sel_B,
    output logic              o_op,
    output logic              w_acc,
    output logic              w_ram,
    output logic              r_ram,
    output logic              h_flg,
    output logic              o_err
);

    localparam int SPW = $clog2(STK_DEPTH + 1);
    localparam int AW  = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    localparam logic [SPW-1:0]    SP_FULL = SPW'(STK_DEPTH);
    localparam logic [SPW-1:0]    SP_ONE  = SPW'(1);
    localparam logic [DTBITS-1:0] PC_INIT = DTBITS'(PC_RST);
    localparam logic [DTBITS-1:0] PC_ONE  = DTBITS'(1);

    localparam logic [OPBITS-1:0] OP_HLT  = OPBITS'(0);
    localparam logic [OPBITS-1:0] OP_STO  = OPBITS'(1);
    localparam logic [OPBITS-1:0] OP_LD   = OPBITS'(2);
    localparam logic [OPBITS-1:0] OP_LDI  = OPBITS'(3);
    localparam logic [OPBITS-1:0] OP_ADD  = OPBITS'(4);
    localparam logic [OPBITS-1:0] OP_ADDI = OPBITS'(5);
    localparam logic [OPBITS-1:0] OP_SUB  = OPBITS'(6);
    localparam logic [OPBITS-1:0] OP_SUBI = OPBITS'(7);
    localparam logic [OPBITS-1:0] OP_JMP  = OPBITS'(8);
    localparam logic [OPBITS-1:0] OP_BEQ  = OPBITS'(9);
    localparam logic [OPBITS-1:0] OP_BNE  = OPBITS'(10);
    localparam logic [OPBITS-1:0] OP_CALL = OPBITS'(11);
    localparam logic [OPBITS-1:0] OP_RET  = OPBITS'(12);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DTBITS-1:0] pc;
    logic [DTBITS-1:0] pc_n;
    logic [DTBITS-1:0] pc_inc;
    logic [BITS-1:0]   ir;
    logic [SPW-1:0]    sp;
    logic [SPW-1:0]    sp_n;
    logic [DTBITS-1:0] stack [STK_DEPTH];
    logic              err;
    logic              err_n;
    logic              push;
    logic              ir_ld;
    logic [OPBITS-1:0] opc;
    logic [DTBITS-1:0] opnd;
    logic [AW-1:0]     push_idx;
    logic [AW-1:0]     pop_idx;

    assign opc      = ir[BITS-1 -: OPBITS];
    assign opnd     = ir[DTBITS-1:0];
    assign pc_inc   = pc + PC_ONE;
    // The pop index is only consumed when sp > 0, so its value at sp == 0 is irrelevant.
    assign push_idx = AW'(sp);
    assign pop_idx  = AW'(sp - SP_ONE);

    assign o_imem_req = (state == S_FETCH);
    assign o_Addr     = pc;
    assign o_Data     = opnd;
    assign h_flg      = (state == S_HALT);
    assign o_err      = err;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_FETCH;
            pc    <= PC_INIT;
            ir    <= '0;
            sp    <= '0;
            err   <= 1'b0;
            for (int i = 0; i < STK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            state <= state_n;
            pc    <= pc_n;
            sp    <= sp_n;
            err   <= err_n;
            if (ir_ld) begin
                ir <= i_Data;
            end
            if (push) begin
                stack[push_idx] <= pc_inc;
            end
        end
    end

    // Strobes decode only from the registered state and IR, so they stay glitch-free for the
    // whole EXEC cycle. Faults keep the PC on the offending instruction.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        sp_n    = sp;
        err_n   = err;
        push    = 1'b0;
        ir_ld   = 1'b0;
        sel_A   = 2'd0;
        sel_B   = 1'b0;
        o_op    = 1'b0;
        w_acc   = 1'b0;
        w_ram   = 1'b0;
        r_ram   = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (i_imem_vld) begin
                    ir_ld   = 1'b1;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n = S_FETCH;
                pc_n    = pc_inc;
                case (opc)
                    OP_HLT: begin
                        state_n = S_HALT;
                        pc_n    = pc;
                    end
                    OP_STO: w_ram = 1'b1;
                    OP_LD: begin
                        r_ram = 1'b1;
                        w_acc = 1'b1;
                    end
                    OP_LDI: begin
                        sel_A = 2'd1;
                        w_acc = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        r_ram = 1'b1;
                        sel_A = 2'd2;
                        o_op  = (opc == OP_SUB);
                        w_acc = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_B = 1'b1;
                        sel_A = 2'd2;
                        o_op  = (opc == OP_SUBI);
                        w_acc = 1'b1;
                    end
                    OP_JMP: pc_n = opnd;
                    OP_BEQ: if (i_zero) pc_n = opnd;
                    OP_BNE: if (!i_zero) pc_n = opnd;
                    OP_CALL: begin
                        if (sp == SP_FULL) begin
                            state_n = S_HALT;
                            pc_n    = pc;
                            err_n   = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + SP_ONE;
                            pc_n = opnd;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            state_n = S_HALT;
                            pc_n    = pc;
                            err_n   = 1'b1;
                        end else begin
                            sp_n = sp - SP_ONE;
                            pc_n = stack[pop_idx];
                        end
                    end
                    default: begin
                        state_n = S_HALT;
                        pc_n    = pc;
                        err_n   = 1'b1;
                    end
                endcase
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed bench for control_seq.
// It drives two instances: the default 16-bit one and a 24-bit one with a one-entry stack.
module tb_control_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int n_chk = 0;
    int n_err = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] d16 = '0;
    logic        v16 = 1'b0;
    logic        z16 = 1'b0;
    logic        req16;
    logic [10:0] addr16;
    logic [10:0] opnd16;
    logic [1:0]  sa16;
    logic        sb16, op16, wa16, wr16, rr16, h16, e16;
    logic [6:0]  sv16;

    logic [23:0] d24 = '0;
    logic        v24 = 1'b0;
    logic        z24 = 1'b0;
    logic        req24;
    logic [18:0] addr24;
    logic [18:0] opnd24;
    logic [1:0]  sa24;
    logic        sb24, op24, wa24, wr24, rr24, h24, e24;
    logic [6:0]  sv24;

    assign sv16 = {sa16, sb16, op16, wa16, wr16, rr16};
    assign sv24 = {sa24, sb24, op24, wa24, wr24, rr24};

    control_seq u16 (
        .i_clk(clk), .i_rst(rst), .i_Data(d16), .i_imem_vld(v16),
        .i_zero(z16), .o_imem_req(req16), .o_Addr(addr16),
        .o_Data(opnd16), .sel_A(sa16), .sel_B(sb16), .o_op(op16),
        .w_acc(wa16), .w_ram(wr16), .r_ram(rr16), .h_flg(h16),
        .o_err(e16)
    );

    control_seq #(.BITS(24), .STK_DEPTH(1)) u24 (
        .i_clk(clk), .i_rst(rst), .i_Data(d24), .i_imem_vld(v24),
        .i_zero(z24), .o_imem_req(req24), .o_Addr(addr24),
        .o_Data(opnd24), .sel_A(sa24), .sel_B(sb24), .o_op(op24),
        .w_acc(wa24), .w_ram(wr24), .r_ram(rr24), .h_flg(h24),
        .o_err(e24)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        v16 = 1'b0;
        v24 = 1'b0;
        #2;
        check("rst_req", {31'd0, req16}, 1);
        check("rst_sv", {25'd0, sv16}, 0);
        check("rst_hf", {30'd0, h16, e16}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        base = cyc;
        check("rst_addr", {21'd0, addr16}, 0);
    endtask

    // Leaves the DUT in EXEC, #1 after the capture edge.
    task automatic exec16(input logic [15:0] ins, input logic z);
        d16 = ins;
        z16 = z;
        v16 = 1'b1;
        tick();
    endtask

    task automatic exec24(input logic [23:0] ins);
        d24 = ins;
        v24 = 1'b1;
        tick();
    endtask

    // {sel_A, sel_B, o_op, w_acc, w_ram, r_ram}
    logic [15:0] dec_ins [4] = '{16'h1012, 16'h2004, 16'h3004, 16'h3804};
    logic [6:0]  dec_exp [4] = '{7'b0000101, 7'b1000101, 7'b1001101, 7'b1011100};

    initial begin
        do_reset();

        // Straight line, vld held high.
        exec16(16'h1805, 1'b0);
        check("ldi_sv", {25'd0, sv16}, 7'b0100100);
        check("ldi_opnd", {21'd0, opnd16}, 5);
        tick();
        check("sl_addr1", {21'd0, addr16}, 1);
        exec16(16'h2803, 1'b0);
        check("addi_sv", {25'd0, sv16}, 7'b1010100);
        tick();
        check("sl_addr2", {21'd0, addr16}, 2);
        exec16(16'h0807, 1'b0);
        check("sto_sv", {25'd0, sv16}, 7'b0000010);
        check("sto_opnd", {21'd0, opnd16}, 7);
        tick();
        check("sl_addr3", {21'd0, addr16}, 3);
        exec16(16'h0000, 1'b0);
        check("hlt_exec_h", {31'd0, h16}, 0);
        tick();
        check("hlt_cyc", cyc - base, 8);
        check("hlt_he", {30'd0, h16, e16}, 2'b10);
        check("hlt_req", {31'd0, req16}, 0);
        tick();
        tick();
        check("hlt_addr", {21'd0, addr16}, 3);
        check("hlt_sv", {25'd0, sv16}, 0);

        // Fetch stall: junk on i_Data must not reach IR.
        do_reset();
        d16 = 16'h0805;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_st", {19'd0, req16, addr16, opnd16[0]}, {1'b1, 12'd0});
            check("stall_sv", {25'd0, sv16}, 0);
        end
        exec16(16'h0809, 1'b0);
        check("stall_cyc", cyc - base, 4);
        check("stall_sv_x", {25'd0, sv16}, 7'b0000010);
        tick();
        check("stall_addr", {21'd0, addr16}, 1);

        // Reset in the middle of a STO EXEC.
        exec16(16'h0809, 1'b0);
        check("mid_wram", {31'd0, wr16}, 1);
        rst = 1'b0;
        #1;
        check("mid_wram0", {31'd0, wr16}, 0);
        check("mid_addr", {21'd0, addr16}, 0);
        do_reset();

        // Branches.
        exec16(16'h4810, 1'b1);
        tick();
        check("beq_t", {21'd0, addr16}, 16'h10);
        exec16(16'h4810, 1'b0);
        tick();
        check("beq_n", {21'd0, addr16}, 16'h11);
        exec16(16'h5010, 1'b0);
        tick();
        check("bne_t", {21'd0, addr16}, 16'h10);
        exec16(16'h5010, 1'b1);
        tick();
        check("bne_n", {21'd0, addr16}, 16'h11);
        exec16(16'h47FF, 1'b0);
        check("jmp_sv", {25'd0, sv16}, 0);
        tick();
        check("jmp", {21'd0, addr16}, 16'h7FF);
        exec16(16'h1801, 1'b0);
        tick();
        check("wrap", {21'd0, addr16}, 0);

        // Remaining decode entries, PC 0..3.
        for (int i = 0; i < 4; i++) begin
            exec16(dec_ins[i], 1'b0);
            check("dec_sv", {25'd0, sv16}, {25'd0, dec_exp[i]});
            tick();
        end
        check("dec_addr", {21'd0, addr16}, 4);

        // CALL/RET, then overflow.
        exec16(16'h5820, 1'b0);
        tick();
        check("call", {21'd0, addr16}, 16'h20);
        exec16(16'h6000, 1'b0);
        tick();
        check("ret", {21'd0, addr16}, 5);
        for (int i = 0; i < 4; i++) begin
            exec16(16'h5830, 1'b0);
            tick();
            check("nest", {20'd0, h16, addr16}, 16'h30);
        end
        exec16(16'h5830, 1'b0);
        tick();
        check("ovf_he", {30'd0, h16, e16}, 2'b11);
        check("ovf_addr", {21'd0, addr16}, 16'h30);

        do_reset();
        exec16(16'h6000, 1'b0);
        tick();
        check("unf_he", {30'd0, h16, e16}, 2'b11);
        check("unf_addr", {21'd0, addr16}, 0);

        do_reset();
        exec16(16'hF800, 1'b0);
        check("ill_sv", {25'd0, sv16}, 0);
        tick();
        check("ill_he", {30'd0, h16, e16}, 2'b11);
        tick();
        check("ill_stay", {29'd0, req16, h16, e16}, 3'b011);

        // 24-bit instance.
        do_reset();
        check("w_req", {31'd0, req24}, 1);
        exec24(24'h180005);
        check("w_ldi", {25'd0, sv24}, 7'b0100100);
        check("w_opnd", {13'd0, opnd24}, 5);
        tick();
        exec24(24'h280003);
        check("w_addi", {25'd0, sv24}, 7'b1010100);
        tick();
        exec24(24'h080007);
        check("w_sto", {25'd0, sv24}, 7'b0000010);
        tick();
        exec24(24'h000000);
        tick();
        check("w_hlt_cyc", cyc - base, 8);
        check("w_hlt", {11'd0, h24, e24, addr24}, {2'b10, 19'd3});

        do_reset();
        exec24(24'h47FFFF);
        tick();
        check("w_jmp", {13'd0, addr24}, 32'h7FFFF);
        exec24(24'h180001);
        tick();
        check("w_wrap", {13'd0, addr24}, 0);
        exec24(24'h580100);
        tick();
        check("w_call", {11'd0, h24, e24, addr24}, 32'h100);
        exec24(24'h580200);
        tick();
        check("w_ovf", {11'd0, h24, e24, addr24}, {2'b11, 19'h100});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/control_seq.md
# control_seq

Parametrised, multi-cycle instruction sequencer for the accumulator CPU. It replaces the single-cycle program-counter/decoder control path. It adds a fetch handshake with instruction memory, absolute jumps, zero-flag conditional branches, and CALL/RET through a bounded return-address stack with overflow and underflow detection. It sits between instruction memory and the accumulator datapath (ALU, accumulator, data RAM).

## Interface

**Parameters**

- `BITS`, 16: instruction width.
- `OPBITS`, 5: opcode field width, instruction `[BITS-1:BITS-OPBITS]`.
- `DTBITS`, `BITS-OPBITS`: operand/address field width, instruction `[DTBITS-1:0]`. Also the PC width.
- `STK_DEPTH`, 4: return-address stack entries (≥1).
- `PC_RST`, 0: PC value after reset.

**Ports**

- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_Data` in `BITS`: instruction word from instruction memory.
- `i_imem_vld` in 1: `i_Data` valid. Sampled only in FETCH.
- `i_zero` in 1: accumulator-equals-zero flag from the datapath.
- `o_imem_req` in/out: out 1, fetch request. High exactly in FETCH.
- `o_Addr` out `DTBITS`: current PC (instruction-memory address).
- `o_Data` out `DTBITS`: IR operand field (RAM address or immediate).
- `sel_A` out 2: accumulator source. 0 = RAM, 1 = immediate, 2 = ALU.
- `sel_B` out 1: ALU operand B. 0 = RAM, 1 = immediate.
- `o_op` out 1: ALU operation. 0 = add, 1 = sub.
- `w_acc`, `w_ram`, `r_ram` out 1 each: accumulator write, RAM write, RAM read strobes.
- `h_flg` out 1: halted.
- `o_err` out 1: halted due to illegal opcode or stack fault.

## Operation

**States**

- FETCH: drives `o_imem_req` = 1 and `o_Addr` = PC.
  - If `i_imem_vld` = 1: IR <= `i_Data`, go to EXEC.
  - Otherwise: stay in FETCH, PC and IR held.
- EXEC: decodes IR for exactly one cycle, asserts the strobes, updates the PC, then goes to FETCH (or HALT).
- HALT: terminal. All strobes are 0 and `o_imem_req` = 0. Only reset leaves HALT.

**Opcodes (IR opcode field; operand is `o_Data`)**

- 00000 HLT: go to HALT, `o_err` = 0.
- 00001 STO: `w_ram` = 1.
- 00010 LD: `r_ram` = 1, `sel_A` = 0, `w_acc` = 1.
- 00011 LDI: `sel_A` = 1, `w_acc` = 1.
- 00100 ADD: `r_ram` = 1, `sel_B` = 0, `o_op` = 0, `sel_A` = 2, `w_acc` = 1.
- 00101 ADDI: same as ADD, but `sel_B` = 1 and `r_ram` = 0.
- 00110 SUB: same as ADD, with `o_op` = 1.
- 00111 SUBI: same as ADDI, with `o_op` = 1.
- 01000 JMP: PC <= operand.
- 01001 BEQ: PC <= operand if `i_zero` = 1 (sampled in EXEC), else PC + 1.
- 01010 BNE: PC <= operand if `i_zero` = 0, else PC + 1.
- 01011 CALL: push PC + 1, then PC <= operand.
- 01100 RET: PC <= popped entry.
- All other codes: illegal. Go to HALT with `o_err` = 1.

**PC and stack rules**

- Sequential update for all non-branching instructions: PC <= PC + 1, modulo 2^`DTBITS`. Wrap from all-ones to 0 is silent.
- Branch targets are absolute, taken from the operand field.
- HLT and illegal opcodes leave the PC unchanged.
- Stack is LIFO, with SP in 0..`STK_DEPTH`.
- CALL with SP = `STK_DEPTH`: no push, PC unchanged, go to HALT with `o_err` = 1.
- RET with SP = 0: same fault behaviour (no pop, PC unchanged, HALT, `o_err` = 1).
- `o_Data` = IR operand at all times. All strobes and `sel_A`/`sel_B`/`o_op` are 0 outside EXEC.

## Timing

**Reset (`i_rst` low, asynchronous)**

- State = FETCH, PC = `PC_RST`, IR = 0, SP = 0, stack contents = 0.
- `o_imem_req` = 1 and `o_Addr` = `PC_RST`, but `i_imem_vld` is not captured until the first rising edge with `i_rst` high.
- All strobes, `sel_A`, `sel_B`, `o_op`, `h_flg` and `o_err` = 0.
- Reset mid-instruction (any state) aborts immediately. No RAM/accumulator strobe survives reset assertion.

**Cycle behaviour**

- Minimum 2 cycles per instruction: FETCH with `i_imem_vld` = 1 same cycle, then EXEC.
- Each wait cycle in FETCH adds one cycle.
- Strobes are decoded from the registered IR and state only, so they are glitch-free and valid for the whole EXEC cycle.
- The datapath acts on the EXEC→next-FETCH edge.
- PC and SP update on the EXEC exit edge. The next FETCH presents the new PC in its first cycle.
- `i_imem_vld` outside FETCH is ignored.
- `i_zero` must be stable during EXEC. It reflects the accumulator before the current instruction.
- `h_flg` rises on the edge leaving EXEC into HALT.
- `o_err` rises on the same edge as `h_flg`, and both stay high until reset.

## Test plan

- **Straight line:** program LDI 5, ADDI 3, STO 7, HLT with `i_imem_vld` tied 1.
  - Strobes match the decode table.
  - Addresses 0,1,2,3 are fetched.
  - `h_flg` = 1 at cycle 8, `o_err` = 0, and `o_Addr` stays 3.
- **Fetch stall:** hold `i_imem_vld` low 3 cycles at PC 0.
  - PC and IR are held, `o_imem_req` stays 1, and no strobes fire.
  - EXEC occurs at cycle 4.
- **Branches:**
  - BEQ 0x10 with `i_zero` = 1 → next `o_Addr` = 0x10.
  - BEQ 0x10 with `i_zero` = 0 → PC + 1.
  - BNE with the inverse flag gives the inverse result.
  - JMP 0x7FF → `o_Addr` = 0x7FF.
  - Sequential instruction at 0x7FF → PC wraps to 0.
- **Stack:** CALL 0x20 from PC 4 → PC = 0x20, then RET → PC = 5.
  - Five nested CALLs with `STK_DEPTH` = 4 → HALT with `o_err` = 1 and PC at the fifth CALL.
  - RET on an empty stack → `o_err` = 1.
- **Illegal opcode and reset:** opcode 11111 → `h_flg` = `o_err` = 1.
  - Assert `i_rst` low mid-EXEC of a STO → `w_ram` drops immediately, and PC = `PC_RST` after release.
- **Width generality:** rerun the straight-line scenario with `BITS` = 24 and `STK_DEPTH` = 1.
  - Second nested CALL faults.
  - Wrap occurs at 2^19 − 1.
